mem_port_arbiter: RTL

Shares the single 32-bit memory port of the RV32I core between instruction fetch (IF) and data memory access (DM, load/store). Arbitrates between the two requesters, drives the select of the 2:1 address/write-data mux, and tracks one outstanding transaction so the read response returns to the requester that issued it. Sits between the fetch/LSU stages and the unified memory interface.

---
 rtl/rv32i_pkg.sv | 29 ++
 rtl/mux2_to_1.sv | 19 +
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg
//   Definitions shared by the memory port arbiter and its helpers:
//   - FSM state encodings for the arbiter (IDLE / REQ / WAIT)
//   - Owner constants driving the mux select (0 = fetch, 1 = data)
//   - arb_pick(): chooses the next owner from the two request lines
package rv32i_pkg;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  // Single requester wins outright; on a tie the caller's tie_owner wins.
  function automatic logic arb_pick(input logic if_req, input logic dm_req,
                                    input logic tie_owner);
    if (if_req && dm_req) begin
      return tie_owner;
    end else if (dm_req) begin
      return OWNER_DM;
    end else begin
      return OWNER_IF;
    end
  endfunction

endpackage

// File: rtl/mux2_to_1.sv
// mux2_to_1
//   Parameterised 2:1 multiplexer.
//   Ports:
//     in0  W-bit input, selected when sel = 0
//     in1  W-bit input, selected when sel = 1
//     sel  select
//     out  W-bit result
module mux2_to_1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port of the RV32I core between instruction
//   fetch (IF) and data memory access (DM). One transaction outstanding at
//   a time; the read response is routed back to the requester that owns
//   the transaction.
//
//   Build option:
//     ARB_ROUND_ROBIN_EN  defined   -> round-robin on simultaneous requests
//                         undefined -> fixed priority, DM over IF
//
//   Ports:
//     clk, rst_n                       clock, asynchronous active-low reset
//     if_req/if_addr                   fetch request (held until if_gnt)
//     if_gnt/if_rvalid/if_rdata        fetch accept / response
//     dm_req/dm_we/dm_addr/dm_wdata/dm_be  data request (held until dm_gnt)
//     dm_gnt/dm_rvalid/dm_rdata        data accept / response
//     mem_req/mem_we/mem_addr/mem_wdata/mem_be  muxed request to memory
//     mem_gnt/mem_rvalid/mem_rdata     memory accept / response
//     sel                              current owner (0 = IF, 1 = DM)
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sel
);

  logic [1:0]        state_reg, state_next;
  logic              sel_reg, sel_next;
  logic              tie_owner;
  logic              in_req, in_wait;
  logic [DATA_W-1:0] if_wdata;

  // Fetch never writes; its write-data leg of the mux is tied to zero.
  assign if_wdata = '0;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_reg;

  // Owner of the most recently granted transaction; a tie goes to the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_reg <= OWNER_DM;
    end else if (state_reg == ST_REQ && mem_gnt) begin
      last_owner_reg <= sel_reg;
    end
  end

  assign tie_owner = ~last_owner_reg;
`else
  assign tie_owner = OWNER_DM;
`endif

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    case (state_reg)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          sel_next   = arb_pick(if_req, dm_req, tie_owner);
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      sel_reg   <= OWNER_IF;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
    end
  end

  assign in_req  = (state_reg == ST_REQ);
  assign in_wait = (state_reg == ST_WAIT);

  mux2_to_1 #(.W(ADDR_W)) u_addr_mux (
    .in0 (if_addr),
    .in1 (dm_addr),
    .sel (sel_reg),
    .out (mem_addr)
  );

  mux2_to_1 #(.W(DATA_W)) u_wdata_mux (
    .in0 (if_wdata),
    .in1 (dm_wdata),
    .sel (sel_reg),
    .out (mem_wdata)
  );

  // Write strobes only leave the arbiter while a data request is presented.
  assign mem_req = in_req;
  assign mem_we  = in_req && (sel_reg == OWNER_DM) && dm_we;
  assign mem_be  = (in_req && (sel_reg == OWNER_DM)) ? dm_be : 4'b0000;
  assign sel     = sel_reg;

  // Accept and response pass straight through to the owner only; a
  // response outside WAIT is a stray and is dropped.
  assign if_gnt    = in_req  && mem_gnt    && (sel_reg == OWNER_IF);
  assign dm_gnt    = in_req  && mem_gnt    && (sel_reg == OWNER_DM);
  assign if_rvalid = in_wait && mem_rvalid && (sel_reg == OWNER_IF);
  assign dm_rvalid = in_wait && mem_rvalid && (sel_reg == OWNER_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule
